// File: rtl/axis_matrix_loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the AXI-Stream matrix loader:
//   - FSM state encoding (legacy-compatible 3-bit constants)
//   - default beat counts of the A, B and C regions
//   - region base offsets within the flat beat stream
//   - a helper that tells whether a state accepts beats
// ---------------------------------------------------------------------------
package loader_pkg;

  localparam int A_WORDS_DEF = 448;  // 64 x 7
  localparam int B_WORDS_DEF = 16;   // 8 x 2
  localparam int C_WORDS_DEF = 3;    // 3 x 1

  localparam int B_BASE = 448;
  localparam int C_BASE = 464;
  localparam int TOTAL  = 467;

  localparam int CNT_W = 9;

  typedef logic [2:0] state_t;

  localparam state_t IDLE   = 3'd0;
  localparam state_t LOAD_A = 3'd1;
  localparam state_t LOAD_B = 3'd2;
  localparam state_t LOAD_C = 3'd3;
  localparam state_t DONE   = 3'd4;

  // Only the three LOAD states take beats from the stream.
  function automatic logic is_loading(input state_t s);
    return (s == LOAD_A) || (s == LOAD_B) || (s == LOAD_C);
  endfunction

endpackage

// File: rtl/axis_matrix_loader_if.sv
// ---------------------------------------------------------------------------
// axis_matrix_loader_if
// AXI-Stream beat channel feeding the matrix loader.
//   TDATA  [31:0] beat payload (only the low WIDTH bits are used)
//   TVALID        upstream beat valid
//   TLAST         upstream end-of-packet marker
//   TREADY        loader can accept a beat
// Modports: master = upstream source, slave = loader.
// ---------------------------------------------------------------------------
interface axis_matrix_loader_if;

  logic [31:0] TDATA;
  logic        TVALID;
  logic        TLAST;
  logic        TREADY;

  modport master (output TDATA, output TVALID, output TLAST, input TREADY);
  modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);

endinterface

// File: rtl/axis_matrix_loader_beat_counter.sv
// ---------------------------------------------------------------------------
// beat_counter
// Counts accepted beats across the whole A/B/C stream and provides the
// offsets of the current beat relative to the B and C region bases.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   i_clear      zero the count (new load armed)
//   i_inc        advance by one (beat accepted)
//   o_count      absolute beat index, also the A-region address
//   o_rel_b      index minus the B base
//   o_rel_c      index minus the C base
// ---------------------------------------------------------------------------
module beat_counter
  import loader_pkg::*;
#(
  parameter int B_BASE_P = B_BASE,
  parameter int C_BASE_P = C_BASE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count,
  output logic [3:0]       o_rel_b,
  output logic [1:0]       o_rel_c
);

  logic [CNT_W-1:0] r_count;

  // Clear has priority over increment; a start never coincides with an
  // accepted beat because start is only honoured outside the LOAD states.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + 9'd1;
    end
  end

  assign o_count = r_count;
  // Truncating the difference gives the region address directly; the
  // result is only consumed while the FSM is inside that region.
  assign o_rel_b = 4'(r_count - 9'(B_BASE_P));
  assign o_rel_c = 2'(r_count - 9'(C_BASE_P));

endmodule

// File: rtl/axis_matrix_loader.sv
// ---------------------------------------------------------------------------
// axis_matrix_loader
// Streams A_WORDS + B_WORDS + C_WORDS beats from an AXI-Stream slave port
// into three separate RAM write ports (A, B, C) in that order, one write
// per accepted beat, issued one cycle after acceptance.
// Ports:
//   ACLK, ARESET  clock and synchronous active-high reset
//   start         single-cycle arm request (honoured in IDLE/DONE only)
//   S_AXIS        beat channel (slave modport)
//   a_we/addr     A RAM write port (9-bit address)
//   b_we/addr     B RAM write port (4-bit address)
//   c_we/addr     C RAM write port (2-bit address)
//   wr_data       write data shared by all three RAM ports
//   load_done     level, high in DONE until the next start
//   tlast_err     sticky TLAST framing error
// Build option: define TLAST_CHECK_EN to enable TLAST framing checks;
// otherwise TLAST is ignored and tlast_err is tied low.
// ---------------------------------------------------------------------------
module axis_matrix_loader
  import loader_pkg::*;
#(
  parameter int A_WORDS = A_WORDS_DEF,
  parameter int B_WORDS = B_WORDS_DEF,
  parameter int C_WORDS = C_WORDS_DEF,
  parameter int WIDTH   = 8
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  input  logic                 start,
  axis_matrix_loader_if.slave  S_AXIS,
  output logic                 a_we,
  output logic                 b_we,
  output logic                 c_we,
  output logic [8:0]           a_addr,
  output logic [3:0]           b_addr,
  output logic [1:0]           c_addr,
  output logic [WIDTH-1:0]     wr_data,
  output logic                 load_done,
  output logic                 tlast_err
);

  localparam int L_B_BASE = A_WORDS;
  localparam int L_C_BASE = A_WORDS + B_WORDS;
  localparam int L_TOTAL  = L_C_BASE + C_WORDS;

  state_t           r_state;
  logic             w_ready;
  logic             w_accept;
  logic             w_start;
  logic [CNT_W-1:0] w_count;
  logic [3:0]       w_rel_b;
  logic [1:0]       w_rel_c;
  logic             w_last_a;
  logic             w_last_b;
  logic             w_last_c;

  logic             r_a_we;
  logic             r_b_we;
  logic             r_c_we;
  logic [8:0]       r_a_addr;
  logic [3:0]       r_b_addr;
  logic [1:0]       r_c_addr;
  logic [WIDTH-1:0] r_wr_data;

  // TREADY is a pure state decode so it never waits on TVALID.
  assign w_ready       = is_loading(r_state);
  assign S_AXIS.TREADY = w_ready;
  assign w_accept      = S_AXIS.TVALID && w_ready;
  assign w_start       = start && ((r_state == IDLE) || (r_state == DONE));

  beat_counter #(
    .B_BASE_P (L_B_BASE),
    .C_BASE_P (L_C_BASE)
  ) u_beat_counter (
    .clk     (ACLK),
    .rst     (ARESET),
    .i_clear (w_start),
    .i_inc   (w_accept),
    .o_count (w_count),
    .o_rel_b (w_rel_b),
    .o_rel_c (w_rel_c)
  );

  // The counter is absolute, so each region ends on a fixed index.
  assign w_last_a = (w_count == 9'(L_B_BASE - 1));
  assign w_last_b = (w_count == 9'(L_C_BASE - 1));
  assign w_last_c = (w_count == 9'(L_TOTAL - 1));

  // Region sequencing: each LOAD state is left on the accepted beat that
  // closes it, so that beat is still tagged with the region it belongs to.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: if (start) r_state <= LOAD_A;
        LOAD_A:     if (w_accept && w_last_a) r_state <= LOAD_B;
        LOAD_B:     if (w_accept && w_last_b) r_state <= LOAD_C;
        LOAD_C:     if (w_accept && w_last_c) r_state <= DONE;
        default:    r_state <= IDLE;
      endcase
    end
  end

  // Write stage: one registered write per accepted beat, steered by the
  // state at acceptance. Reset drops a write that was about to be issued.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_a_we    <= 1'b0;
      r_b_we    <= 1'b0;
      r_c_we    <= 1'b0;
      r_a_addr  <= '0;
      r_b_addr  <= '0;
      r_c_addr  <= '0;
      r_wr_data <= '0;
    end else begin
      r_a_we <= w_accept && (r_state == LOAD_A);
      r_b_we <= w_accept && (r_state == LOAD_B);
      r_c_we <= w_accept && (r_state == LOAD_C);
      if (w_accept) begin
        r_wr_data <= S_AXIS.TDATA[WIDTH-1:0];
        case (r_state)
          LOAD_A:  r_a_addr <= w_count;
          LOAD_B:  r_b_addr <= w_rel_b;
          LOAD_C:  r_c_addr <= w_rel_c;
          default: r_a_addr <= r_a_addr;
        endcase
      end
    end
  end

  assign a_we      = r_a_we;
  assign b_we      = r_b_we;
  assign c_we      = r_c_we;
  assign a_addr    = r_a_addr;
  assign b_addr    = r_b_addr;
  assign c_addr    = r_c_addr;
  assign wr_data   = r_wr_data;
  // DONE is entered on the same edge that issues the final C write.
  assign load_done = (r_state == DONE);

`ifdef TLAST_CHECK_EN
  logic r_tlast_err;
  logic w_final_beat;

  assign w_final_beat = (r_state == LOAD_C) && w_last_c;

  // TLAST must be high on the final beat and low on every other one;
  // the error is sticky until the next load is armed.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_tlast_err <= 1'b0;
    end else if (w_start) begin
      r_tlast_err <= 1'b0;
    end else if (w_accept && (S_AXIS.TLAST != w_final_beat)) begin
      r_tlast_err <= 1'b1;
    end
  end

  assign tlast_err = r_tlast_err;
`else
  assign tlast_err = 1'b0;
`endif

  // Payload bits above WIDTH (and TLAST when unchecked) are intentionally
  // ignored; folding them here keeps them visibly accounted for.
  generate
    if (WIDTH < 32) begin : g_unused
      logic w_unused_bits;
      assign w_unused_bits = ^{S_AXIS.TDATA[31:WIDTH], S_AXIS.TLAST};
    end else begin : g_unused_tlast
      logic w_unused_bits;
      assign w_unused_bits = S_AXIS.TLAST;
    end
  endgenerate

endmodule

// File: tb/tb_axis_matrix_loader.sv
// ---------------------------------------------------------------------------
// tb_axis_matrix_loader
// Directed bench for axis_matrix_loader: reset values, idle behaviour,
// full loads with and without TVALID gaps, mid-load reset, TLAST framing
// and re-arming from DONE. A negedge monitor logs every RAM write; tasks
// compare that log against a hand-built model of the beat stream.
// ---------------------------------------------------------------------------
module tb_axis_matrix_loader;

  typedef struct packed {
    logic [1:0] region;  // 1=A, 2=B, 3=C, 0=more than one enable
    logic [8:0] addr;
    logic [7:0] data;
    logic       done;
  } wrEvent_t;

`ifdef TLAST_CHECK_EN
  localparam logic EXP_ERR_EARLY_TLAST = 1'b1;
`else
  localparam logic EXP_ERR_EARLY_TLAST = 1'b0;
`endif

  logic       ACLK;
  logic       ARESET;
  logic       start;
  logic       a_we, b_we, c_we;
  logic [8:0] a_addr;
  logic [3:0] b_addr;
  logic [1:0] c_addr;
  logic [7:0] wr_data;
  logic       load_done;
  logic       tlast_err;

  int tests;
  int failed;

  wrEvent_t wrLog[$];
  wrEvent_t ev;

  axis_matrix_loader_if S_AXIS ();

  axis_matrix_loader dut (
    .ACLK      (ACLK),
    .ARESET    (ARESET),
    .start     (start),
    .S_AXIS    (S_AXIS),
    .a_we      (a_we),
    .b_we      (b_we),
    .c_we      (c_we),
    .a_addr    (a_addr),
    .b_addr    (b_addr),
    .c_addr    (c_addr),
    .wr_data   (wr_data),
    .load_done (load_done),
    .tlast_err (tlast_err)
  );

  // 10 ns clock.
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Write monitor, sampled on the falling edge away from register updates.
  always @(negedge ACLK) begin
    if (a_we || b_we || c_we) begin
      if ($countones({a_we, b_we, c_we}) > 1)
        ev.region = 2'd0;
      else if (a_we)
        ev.region = 2'd1;
      else if (b_we)
        ev.region = 2'd2;
      else
        ev.region = 2'd3;
      ev.addr = a_we ? a_addr : (b_we ? {5'b0, b_addr} : {7'b0, c_addr});
      ev.data = wr_data;
      ev.done = load_done;
      wrLog.push_back(ev);
    end
  end

  // Model of the write for stream beat i: regions split at 448 and 464,
  // data is the beat index modulo 256, done only with the 467th write.
  function automatic wrEvent_t expEvent(input int i);
    wrEvent_t e;
    if (i < 448) begin
      e.region = 2'd1;
      e.addr   = 9'(i);
    end else if (i < 464) begin
      e.region = 2'd2;
      e.addr   = 9'(i - 448);
    end else begin
      e.region = 2'd3;
      e.addr   = 9'(i - 464);
    end
    e.data = 8'(i);
    e.done = (i == 466);
    return e;
  endfunction

  // Hold TVALID at a level for a number of cycles.
  task automatic applyStimulus(input logic valid, input int cycles);
    S_AXIS.TVALID = valid;
    S_AXIS.TLAST  = 1'b0;
    repeat (cycles) begin
      @(posedge ACLK);
      #1;
    end
  endtask

  // Single-cycle start pulse.
  task automatic applyStart();
    start = 1'b1;
    @(posedge ACLK);
    #1;
    start = 1'b0;
  endtask

  // Drive the 467-beat stream. gap1/gap2 insert a 2-cycle TVALID drop
  // before that beat, tlastBeat raises TLAST on one beat, startAt pulses
  // start together with a beat, abortAt resets instead of sending it.
  task automatic runLoad(input int gap1, input int gap2, input int tlastBeat,
                         input int startAt, input int abortAt);
    int   tries;
    logic acc;
    for (int idx = 0; idx < 467; idx++) begin
      if (idx == gap1 || idx == gap2) begin
        S_AXIS.TVALID = 1'b0;
        repeat (2) begin
          @(posedge ACLK);
          #1;
        end
      end
      S_AXIS.TVALID = 1'b1;
      S_AXIS.TDATA  = {16'hA5A5, 16'(idx)};
      S_AXIS.TLAST  = (idx == tlastBeat);
      if (idx == abortAt) begin
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;
        ARESET        = 1'b0;
        S_AXIS.TVALID = 1'b0;
        S_AXIS.TLAST  = 1'b0;
        return;
      end
      start = (idx == startAt);
      tries = 0;
      do begin
        acc = S_AXIS.TREADY;
        @(posedge ACLK);
        #1;
        tries++;
      end while (!acc && tries < 8);
      start = 1'b0;
      if (!acc) begin
        tests++;
        failed++;
        $display("[TB] FAIL beat_accept idx=%0d: TREADY got 0, need 1", idx);
        S_AXIS.TVALID = 1'b0;
        return;
      end
    end
    S_AXIS.TVALID = 1'b0;
    S_AXIS.TLAST  = 1'b0;
  endtask

  task automatic test_reset();
    ARESET        = 1'b1;
    start         = 1'b0;
    S_AXIS.TVALID = 1'b0;
    S_AXIS.TLAST  = 1'b0;
    S_AXIS.TDATA  = 32'h0;
    repeat (3) begin
      @(posedge ACLK);
      #1;
    end
    tests++;
    if (S_AXIS.TREADY !== 1'b0) begin
      failed++;
      $display("[TB] FAIL reset_tready: got %b, need 0", S_AXIS.TREADY);
    end
    tests++;
    if ({a_we, b_we, c_we} !== 3'b000) begin
      failed++;
      $display("[TB] FAIL reset_we: got %b, need 000", {a_we, b_we, c_we});
    end
    tests++;
    if ({a_addr, b_addr, c_addr} !== 15'd0) begin
      failed++;
      $display("[TB] FAIL reset_addr: got %h, need 0", {a_addr, b_addr, c_addr});
    end
    tests++;
    if (wr_data !== 8'h00) begin
      failed++;
      $display("[TB] FAIL reset_wr_data: got %h, need 00", wr_data);
    end
    tests++;
    if (load_done !== 1'b0) begin
      failed++;
      $display("[TB] FAIL reset_load_done: got %b, need 0", load_done);
    end
    tests++;
    if (tlast_err !== 1'b0) begin
      failed++;
      $display("[TB] FAIL reset_tlast_err: got %b, need 0", tlast_err);
    end
    ARESET = 1'b0;
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_pre_start();
    int base;
    base          = wrLog.size();
    S_AXIS.TDATA  = 32'h0000_0077;
    S_AXIS.TVALID = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge ACLK);
      #1;
      tests++;
      if (S_AXIS.TREADY !== 1'b0) begin
        failed++;
        $display("[TB] FAIL pre_start_tready cycle %0d: got %b, need 0", c, S_AXIS.TREADY);
      end
    end
    S_AXIS.TVALID = 1'b0;
    tests++;
    if (wrLog.size() - base !== 0) begin
      failed++;
      $display("[TB] FAIL pre_start_writes: got %0d writes, need 0", wrLog.size() - base);
    end
  endtask

  task automatic test_full_load();
    int base;
    wrEvent_t got, exp;
    base = wrLog.size();
    applyStart();
    tests++;
    if (S_AXIS.TREADY !== 1'b1) begin
      failed++;
      $display("[TB] FAIL full_tready_after_start: got %b, need 1", S_AXIS.TREADY);
    end
    runLoad(-1, -1, 466, -1, -1);
    applyStimulus(1'b1, 3);
    tests++;
    if (wrLog.size() - base !== 467) begin
      failed++;
      $display("[TB] FAIL full_count: got %0d writes, need 467", wrLog.size() - base);
    end
    for (int i = 0; i < 467; i++) begin
      if (base + i < wrLog.size()) begin
        got = wrLog[base + i];
        exp = expEvent(i);
        tests++;
        if (got !== exp) begin
          failed++;
          $display("[TB] FAIL full_write %0d: got rg=%0d a=%0d d=%h dn=%b, need rg=%0d a=%0d d=%h dn=%b",
                   i, got.region, got.addr, got.data, got.done,
                   exp.region, exp.addr, exp.data, exp.done);
        end
      end
    end
    tests++;
    if (load_done !== 1'b1) begin
      failed++;
      $display("[TB] FAIL full_load_done_held: got %b, need 1", load_done);
    end
    tests++;
    if (S_AXIS.TREADY !== 1'b0) begin
      failed++;
      $display("[TB] FAIL full_tready_done: got %b, need 0", S_AXIS.TREADY);
    end
    applyStimulus(1'b0, 1);
  endtask

  task automatic test_gaps();
    int base;
    wrEvent_t got, exp;
    base = wrLog.size();
    applyStart();
    runLoad(3, 447, 466, 455, -1);
    applyStimulus(1'b0, 2);
    tests++;
    if (wrLog.size() - base !== 467) begin
      failed++;
      $display("[TB] FAIL gaps_count: got %0d writes, need 467", wrLog.size() - base);
    end
    for (int i = 0; i < 467; i++) begin
      if (base + i < wrLog.size()) begin
        got = wrLog[base + i];
        exp = expEvent(i);
        tests++;
        if (got !== exp) begin
          failed++;
          $display("[TB] FAIL gaps_write %0d: got rg=%0d a=%0d d=%h dn=%b, need rg=%0d a=%0d d=%h dn=%b",
                   i, got.region, got.addr, got.data, got.done,
                   exp.region, exp.addr, exp.data, exp.done);
        end
      end
    end
  endtask

  task automatic test_tlast();
    int base;
    base = wrLog.size();
    applyStart();
    runLoad(-1, -1, 100, -1, -1);
    applyStimulus(1'b0, 2);
    tests++;
    if (tlast_err !== EXP_ERR_EARLY_TLAST) begin
      failed++;
      $display("[TB] FAIL tlast_early_err: got %b, need %b", tlast_err, EXP_ERR_EARLY_TLAST);
    end
    tests++;
    if (wrLog.size() - base !== 467 || load_done !== 1'b1) begin
      failed++;
      $display("[TB] FAIL tlast_early_complete: got %0d writes done=%b, need 467 done=1",
               wrLog.size() - base, load_done);
    end
    base = wrLog.size();
    applyStart();
    tests++;
    if (tlast_err !== 1'b0) begin
      failed++;
      $display("[TB] FAIL tlast_clear_on_start: got %b, need 0", tlast_err);
    end
    runLoad(-1, -1, 466, -1, -1);
    applyStimulus(1'b0, 2);
    tests++;
    if (tlast_err !== 1'b0) begin
      failed++;
      $display("[TB] FAIL tlast_final_only_err: got %b, need 0", tlast_err);
    end
    tests++;
    if (wrLog.size() - base !== 467 || load_done !== 1'b1) begin
      failed++;
      $display("[TB] FAIL tlast_final_complete: got %0d writes done=%b, need 467 done=1",
               wrLog.size() - base, load_done);
    end
  endtask

  task automatic test_abort();
    int base;
    wrEvent_t got, exp;
    base = wrLog.size();
    applyStart();
    runLoad(-1, -1, 466, -1, 200);
    tests++;
    if (S_AXIS.TREADY !== 1'b0 || {a_we, b_we, c_we} !== 3'b000) begin
      failed++;
      $display("[TB] FAIL abort_quiet: got tready=%b we=%b, need 0 000",
               S_AXIS.TREADY, {a_we, b_we, c_we});
    end
    tests++;
    if (a_addr !== 9'd0 || wr_data !== 8'h00 || load_done !== 1'b0) begin
      failed++;
      $display("[TB] FAIL abort_regs: got a_addr=%0d data=%h done=%b, need 0 00 0",
               a_addr, wr_data, load_done);
    end
    applyStimulus(1'b1, 3);
    tests++;
    if (wrLog.size() - base !== 200) begin
      failed++;
      $display("[TB] FAIL abort_count: got %0d writes, need 200", wrLog.size() - base);
    end
    tests++;
    if (S_AXIS.TREADY !== 1'b0) begin
      failed++;
      $display("[TB] FAIL abort_needs_start: got tready=%b, need 0", S_AXIS.TREADY);
    end
    applyStimulus(1'b0, 1);
    base = wrLog.size();
    applyStart();
    runLoad(-1, -1, 466, -1, -1);
    applyStimulus(1'b0, 2);
    tests++;
    if (wrLog.size() - base !== 467) begin
      failed++;
      $display("[TB] FAIL abort_reload_count: got %0d writes, need 467", wrLog.size() - base);
    end
    for (int i = 0; i < 467; i++) begin
      if (base + i < wrLog.size()) begin
        got = wrLog[base + i];
        exp = expEvent(i);
        tests++;
        if (got !== exp) begin
          failed++;
          $display("[TB] FAIL abort_reload_write %0d: got rg=%0d a=%0d d=%h dn=%b, need rg=%0d a=%0d d=%h dn=%b",
                   i, got.region, got.addr, got.data, got.done,
                   exp.region, exp.addr, exp.data, exp.done);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int base;
    wrEvent_t got, exp;
    tests++;
    if (load_done !== 1'b1) begin
      failed++;
      $display("[TB] FAIL b2b_done_before: got %b, need 1", load_done);
    end
    base = wrLog.size();
    applyStart();
    tests++;
    if (load_done !== 1'b0 || S_AXIS.TREADY !== 1'b1) begin
      failed++;
      $display("[TB] FAIL b2b_rearm: got done=%b tready=%b, need 0 1", load_done, S_AXIS.TREADY);
    end
    runLoad(-1, -1, 466, -1, -1);
    applyStimulus(1'b1, 2);
    tests++;
    if (wrLog.size() - base !== 467) begin
      failed++;
      $display("[TB] FAIL b2b_count: got %0d writes, need 467", wrLog.size() - base);
    end
    for (int i = 0; i < 467; i++) begin
      if (base + i < wrLog.size()) begin
        got = wrLog[base + i];
        exp = expEvent(i);
        tests++;
        if (got !== exp) begin
          failed++;
          $display("[TB] FAIL b2b_write %0d: got rg=%0d a=%0d d=%h dn=%b, need rg=%0d a=%0d d=%h dn=%b",
                   i, got.region, got.addr, got.data, got.done,
                   exp.region, exp.addr, exp.data, exp.done);
        end
      end
    end
    applyStimulus(1'b0, 1);
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    test_reset();
    test_pre_start();
    test_full_load();
    test_gaps();
    test_tlast();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Overall time bound in case the DUT stalls a handshake indefinitely.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/axis_matrix_loader.md
AXIS_MATRIX_LOADER -- requirements
Module: axis_matrix_loader

Interface
REQ-001 Parameter A_WORDS, default 448, number of A-matrix beats (64x7).
REQ-002 Parameter B_WORDS, default 16, number of B-matrix beats (8x2).
REQ-003 Parameter C_WORDS, default 3, number of C-matrix beats (3x1).
REQ-004 Parameter WIDTH, default 8, payload width taken from TDATA[WIDTH-1:0].
REQ-005 ACLK  in  1  the single clock; all logic SHALL be on its rising edge.
REQ-006 ARESET  in  1  reset, synchronous and active-high.
REQ-007 start  in  1  single-cycle arm request for one load.
REQ-008 S_AXIS_TDATA  in  32  beat data; bits 31:WIDTH are ignored.
REQ-009 S_AXIS_TVALID  in  1  upstream beat valid.
REQ-010 S_AXIS_TLAST  in  1  upstream end-of-packet marker.
REQ-011 S_AXIS_TREADY  out  1  loader can accept a beat.
REQ-012 a_we / b_we / c_we  out  1 each  RAM write enables, mutually exclusive.
REQ-013 a_addr / b_addr / c_addr  out  9 / 4 / 2  RAM write addresses.
REQ-014 wr_data  out  WIDTH  data shared by all three RAM ports.
REQ-015 load_done  out  1  level; all beats have been written.
REQ-016 tlast_err  out  1  sticky TLAST framing error.

Function
REQ-017 FSM states: IDLE, LOAD_A, LOAD_B, LOAD_C, DONE.
REQ-018 IDLE or DONE with start=1 -> LOAD_A next cycle; the beat counter clears to 0 and tlast_err clears.
REQ-019 start SHALL be ignored in LOAD_A/B/C.
REQ-020 S_AXIS_TREADY=1 exactly in LOAD_A/B/C and SHALL NOT depend on S_AXIS_TVALID.
REQ-021 A beat is accepted only on a cycle with TVALID=1 and TREADY=1; TVALID=1 with TREADY=0 SHALL leave state unchanged.
REQ-022 An accepted beat k SHALL be written one cycle later: the write enable of the current region=1, addr=k minus the region base, wr_data=TDATA[WIDTH-1:0] (registered).
REQ-023 Transitions occur on the accepted beat that is last in each region: index A_WORDS-1 -> LOAD_B, +B_WORDS-1 -> LOAD_C, +C_WORDS-1 -> DONE.
REQ-024 The beat accepted in the final cycle of a region is written to that region's RAM, not the next.
REQ-025 Gaps in TVALID (any length) SHALL only stall; no beat lost or duplicated.
REQ-026 load_done=1 in DONE, coincident with the final c_we pulse, and held until start.
REQ-027 When the state is not LOAD_*, all write enables SHALL be 0 from the cycle after the final beat onward.

Reset
REQ-028 ARESET=1 SHALL drive the following on the next edge: state IDLE, counter 0, TREADY 0, all write enables 0, addresses 0, wr_data 0, load_done 0, tlast_err 0.
REQ-029 ARESET mid-load SHALL abandon the load; a pending write SHALL NOT be issued; a new start is required.

Configuration
REQ-030 Macro TLAST_CHECK_EN defined: tlast_err is set if TLAST=1 on an accepted beat other than the final one, or TLAST=0 on the final one; the loader SHALL still complete by count.
REQ-031 Macro undefined: TLAST is ignored and tlast_err is tied 0.

Structure
REQ-032 Package loader_pkg SHALL hold the state enum, the default word counts, and the region base constants (B_BASE=448, C_BASE=464, TOTAL=467).
REQ-033 Sub-module beat_counter (counter with clear and increment, 9-bit plus region-relative outputs) is the only sub-module.

Verification
REQ-034 Reset, then start, then 467 beats with TVALID continuously 1 and data=index mod 256: a_addr 0..447, b_addr 0..15, c_addr 0..2, with data matching; load_done on the cycle of the last c_we.
REQ-035 TVALID dropped for 2 cycles at beats 3 and 447: no missing or repeated addresses; b_we first fires on beat 448.
REQ-036 TVALID=1 before start: TREADY stays 0 and no write enable fires until LOAD_A.
REQ-037 ARESET for 1 cycle at beat 200, then start and a full load: the A RAM shows 448 fresh writes, and load_done occurs only after the second load.
REQ-038 With TLAST_CHECK_EN, TLAST on beat 100: tlast_err=1 sticky, load still completes at 467; TLAST on beat 466 only: tlast_err=0.
REQ-039 Second start in DONE: load_done drops next cycle and the second 467-beat load repeats REQ-034 results.
